// File: rtl/imem_program_encoder_if.sv
// Descriptor input and instruction-memory write port of imem_program_encoder.
// The slave modport is the encoder's view; master is the loader/memory side.
interface imem_program_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_mnem;
    logic [2:0]        in_funct;
    logic              in_vec;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [24:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_mnem, in_funct, in_vec, in_rd, in_rn, in_rm, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_mnem, in_funct, in_vec, in_rd, in_rn, in_rm, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_program_encoder.sv
// Packs symbolic instruction descriptors into 32-bit words and writes them to imem.
// Optional macro IMEM_ENC_VECTOR_MEM_EN: str/ldr V bit taken from in_vec.
module imem_program_encoder #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    imem_program_encoder_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W:0]       count
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_WRITE, S_DONE, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;

    logic [31:0] enc_word;
    logic [2:0]  enc_op;
    logic        enc_v, enc_legal, mnem_ok, imm_chk, imm_fits, vec_bit;

`ifdef IMEM_ENC_VECTOR_MEM_EN
    assign vec_bit = bus.in_vec;
`else
    logic vec_unused;
    assign vec_unused = bus.in_vec;
    assign vec_bit    = 1'b0;
`endif

    // Immediate fits in signed 15 bits when its top 11 bits are a pure sign extension
    assign imm_fits = (&bus.in_imm[24:14]) | ~(|bus.in_imm[24:14]);

    always_comb begin
        enc_op  = 3'b000;
        enc_v   = 1'b0;
        imm_chk = 1'b1;
        mnem_ok = 1'b1;
        case (bus.in_mnem)
            4'd0:    imm_chk = 1'b0;
            4'd1:    begin enc_op = 3'b100; enc_v = 1'b1; end
            4'd2:    begin enc_op = 3'b101; enc_v = 1'b1; end
            4'd3:    begin enc_op = 3'b110; enc_v = 1'b1; end
            4'd4:    enc_op = 3'b100;
            4'd5:    enc_op = 3'b101;
            4'd6:    enc_op = 3'b110;
            4'd7:    begin enc_op = 3'b001; enc_v = vec_bit; end
            4'd8:    begin enc_op = 3'b010; enc_v = vec_bit; end
            4'd9:    begin enc_op = 3'b111; enc_v = 1'b1; imm_chk = 1'b0; end
            4'd10:   enc_op = 3'b111;
            default: mnem_ok = 1'b0;
        endcase
        enc_word = {enc_op, enc_v, 3'b000, bus.in_rd, bus.in_rn, bus.in_imm[14:0]};
        if (bus.in_mnem == 4'd0)
            enc_word[27:0] = {bus.in_funct, bus.in_rd, bus.in_rn, bus.in_rm, 10'b0};
        if (bus.in_mnem == 4'd9)
            enc_word[24:0] = bus.in_imm;
        enc_legal = mnem_ok & (~imm_chk | imm_fits);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = ADDR_W'(BASE_ADDR);
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    if (enc_legal) begin
                        state_d = S_WRITE;
                        wdata_d = enc_word;
                        last_d  = bus.in_last;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q + (ADDR_W+1)'(1);
                // A final descriptor may land on the top address; anything after it would wrap
                if (last_q)
                    state_d = S_DONE;
                else if (addr_q == {ADDR_W{1'b1}})
                    state_d = S_ERR;
                else
                    state_d = S_RUN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= ADDR_W'(BASE_ADDR);
            cnt_q   <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready   = (state_q == S_RUN);
    assign bus.imem_we    = (state_q == S_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q == S_RUN) || (state_q == S_WRITE);
    assign done           = (state_q == S_DONE);
    assign err            = (state_q == S_ERR);
    assign count          = cnt_q;
endmodule

// File: tb/tb_imem_program_encoder.sv
// Self-checking bench for imem_program_encoder: vector table, hand sequences, random sessions.
// A second ADDR_W=2 instance shares the stimulus and is used for the address-overflow cases.
module tb_imem_program_encoder;
    typedef struct packed {
        logic [3:0]  mnem;
        logic [2:0]  funct;
        logic        vec;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [24:0] imm;
        logic        last;
    } desc_t;

    typedef struct {
        desc_t       d;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    localparam int OP_TAB [11] = '{0, 4, 5, 6, 4, 5, 6, 1, 2, 7, 7};
    localparam int V_TAB  [11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
`ifdef IMEM_ENC_VECTOR_MEM_EN
    localparam logic [31:0] LDR_W = 32'h50428008;
    localparam logic [31:0] STR_W = 32'h30000000;
`else
    localparam logic [31:0] LDR_W = 32'h40428008;
    localparam logic [31:0] STR_W = 32'h20000000;
`endif

    logic       clk, rst, start;
    logic       busy, done, err, busy2, done2, err2;
    logic [8:0] count;
    logic [2:0] count2;
    int         n_cmp = 0, n_bad = 0, wr_cnt = 0;

    imem_program_encoder_if #(.ADDR_W(8)) bus ();
    imem_program_encoder_if #(.ADDR_W(2)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_mnem  = bus.in_mnem;
    assign bus2.in_funct = bus.in_funct;
    assign bus2.in_vec   = bus.in_vec;
    assign bus2.in_rd    = bus.in_rd;
    assign bus2.in_rn    = bus.in_rn;
    assign bus2.in_rm    = bus.in_rm;
    assign bus2.in_imm   = bus.in_imm;
    assign bus2.in_last  = bus.in_last;

    imem_program_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    imem_program_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .bus(bus2),
        .busy(busy2), .done(done2), .err(err2), .count(count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts words actually committed to memory (the memory samples on the rising edge)
    always @(posedge clk) if (bus.imem_we === 1'b1) wr_cnt <= wr_cnt + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic desc_t mk(input int m, input int f, input int v, input int rd, input int rn,
                                 input int rm, input logic [24:0] imm, input bit last);
        desc_t d;
        d.mnem = 4'(m); d.funct = 3'(f); d.vec = 1'(v);
        d.rd = 5'(rd); d.rn = 5'(rn); d.rm = 5'(rm);
        d.imm = imm; d.last = last;
        return d;
    endfunction

    // Reference encoding straight from the field tables and arithmetic placement
    function automatic void model(input desc_t d, output bit legal, output logic [31:0] w);
        int     m, simm, vb;
        longint acc;
        m    = int'(d.mnem);
        simm = int'($signed(d.imm));
        if (m > 10) begin
            legal = 1'b0;
            w     = 32'h0;
            return;
        end
        vb = V_TAB[m];
`ifdef IMEM_ENC_VECTOR_MEM_EN
        if (m == 7 || m == 8) vb = int'(d.vec);
`endif
        legal = (m == 0 || m == 9) || (simm >= -16384 && simm <= 16383);
        acc = longint'(OP_TAB[m]) * 536870912 + longint'(vb) * 268435456;
        if (m == 9) begin
            acc += longint'(d.imm);
        end else begin
            acc += longint'(d.rd) * 1048576 + longint'(d.rn) * 32768;
            if (m == 0)
                acc += longint'(d.funct) * 33554432 + longint'(d.rm) * 1024;
            else
                acc += longint'(simm & 32767);
        end
        w = acc[31:0];
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input desc_t d);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_mnem  = d.mnem;  bus.in_funct = d.funct; bus.in_vec = d.vec;
        bus.in_rd    = d.rd;    bus.in_rn    = d.rn;    bus.in_rm  = d.rm;
        bus.in_imm   = d.imm;   bus.in_last  = d.last;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic xfer(input desc_t d, input bit el, input logic [31:0] ew, input int ea, input string tag);
        send(d);
        if (el) begin
            chk({tag, "_we"},    64'(bus.imem_we),    64'd1);
            chk({tag, "_addr"},  64'(bus.imem_addr),  64'(ea));
            chk({tag, "_wdata"}, 64'(bus.imem_wdata), 64'(ew));
            chk({tag, "_rdy_in_write"}, 64'(bus.in_ready), 64'd0);
            @(negedge clk);
            if (d.last) begin
                chk({tag, "_done"},  64'(done),  64'd1);
                chk({tag, "_count"}, 64'(count), 64'(ea + 1));
                chk({tag, "_hold"},  64'(bus.imem_wdata), 64'(ew));
                @(negedge clk);
                chk({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
            end
        end else begin
            chk({tag, "_err"}, 64'(err), 64'd1);
            chk({tag, "_no_we"}, 64'(bus.imem_we), 64'd0);
            chk({tag, "_rdy_err"}, 64'(bus.in_ready), 64'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   64'(bus.in_ready),   64'd0);
        chk({tag, "_we"},    64'(bus.imem_we),    64'd0);
        chk({tag, "_addr"},  64'(bus.imem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
        chk({tag, "_flags"}, 64'({busy, done, err}), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        vec_t  tbl[$];
        desc_t d;
        bit    el;
        logic [31:0] ew;
        int    snap;

        tbl.push_back('{mk(1, 0, 0, 3, 1, 0, 25'd5, 1'b1),              1'b1, 32'h90308005});
        tbl.push_back('{mk(0, 5, 0, 31, 0, 31, 25'd0, 1'b1),            1'b1, 32'h0BF07C00});
        tbl.push_back('{mk(8, 0, 1, 4, 5, 0, 25'd8, 1'b1),              1'b1, LDR_W});
        tbl.push_back('{mk(7, 0, 1, 0, 0, 0, 25'd0, 1'b1),              1'b1, STR_W});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 25'h0004000, 1'b1),        1'b0, 32'h0});
        tbl.push_back('{mk(12, 0, 0, 0, 0, 0, 25'd0, 1'b1),             1'b0, 32'h0});
        tbl.push_back('{mk(2, 0, 0, 0, 0, 0, 25'h1FFC000, 1'b1),        1'b1, 32'hB0004000});
        tbl.push_back('{mk(9, 0, 0, 0, 0, 0, 25'h1FFFFFF, 1'b1),        1'b1, 32'hF1FFFFFF});
        tbl.push_back('{mk(3, 0, 0, 0, 0, 0, 25'h0003FFF, 1'b1),        1'b1, 32'hD0003FFF});
        tbl.push_back('{mk(6, 0, 0, 0, 0, 0, 25'h1FFBFFF, 1'b1),        1'b0, 32'h0});
        tbl.push_back('{mk(0, 0, 0, 2, 4, 6, 25'h1FFFFFF, 1'b1),        1'b1, 32'h00221800});
        tbl.push_back('{mk(5, 0, 0, 7, 9, 0, 25'h0000123, 1'b1),        1'b1, 32'hA0748123});
        tbl.push_back('{mk(15, 0, 0, 1, 1, 1, 25'd1, 1'b1),             1'b0, 32'h0});

        rst = 1'b0; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_mnem = '0; bus.in_funct = '0; bus.in_vec = 1'b0;
        bus.in_rd = '0; bus.in_rn = '0; bus.in_rm = '0; bus.in_imm = '0; bus.in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_start();
            xfer(tbl[i].d, tbl[i].legal, tbl[i].word, 0, $sformatf("vec%0d", i));
        end

        // Back-to-back session; start held during RUN/WRITE must be ignored
        do_start();
        start = 1'b1;
        xfer(mk(0, 0, 0, 2, 4, 6, 25'd0, 1'b0), 1'b1, 32'h00221800, 0, "b2b0");
        start = 1'b0;
        xfer(mk(9, 0, 0, 0, 0, 0, 25'h10, 1'b0), 1'b1, 32'hF0000010, 1, "b2b1");
        xfer(mk(10, 0, 0, 1, 2, 0, 25'h1FFFFFF, 1'b1), 1'b1, 32'hE0117FFF, 2, "b2b2");

        // Error after one write, sticky, then restart from the base address
        do_start();
        xfer(mk(1, 0, 0, 1, 1, 0, 25'd1, 1'b0), 1'b1, 32'h90108001, 0, "errpre");
        snap = wr_cnt;
        xfer(mk(1, 0, 0, 0, 0, 0, 25'h0004000, 1'b1), 1'b0, 32'h0, 1, "errimm");
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_no_write", 64'(wr_cnt), 64'(snap));
        do_start();
        chk("err_cleared", 64'({err, bus.in_ready}), 64'b01);
        xfer(mk(1, 0, 0, 3, 1, 0, 25'd5, 1'b1), 1'b1, 32'h90308005, 0, "errrestart");

        // ADDR_W=2 instance: four non-last words overflow; four with last on the top address finish
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(mk(1, 0, 0, i, 0, 0, 25'(i), 1'b0));
            chk("ovf_we",   64'(bus2.imem_we),   64'd1);
            chk("ovf_addr", 64'(bus2.imem_addr), 64'(i));
            @(negedge clk);
        end
        chk("ovf_err_done", 64'({err2, done2, busy2}), 64'b100);
        chk("ovf_count", 64'(count2), 64'd4);
        @(negedge clk);
        chk("ovf_no_we", 64'({bus2.imem_we, err2}), 64'b01);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(mk(1, 0, 0, i, 0, 0, 25'(i), i == 3));
            chk("top_we", 64'({bus2.imem_we, bus2.imem_addr}), 64'({1'b1, 2'(i)}));
            @(negedge clk);
        end
        chk("top_done_err", 64'({done2, err2}), 64'b10);
        chk("top_count", 64'(count2), 64'd4);
        @(negedge clk);

        // Reset landing in a WRITE cycle aborts the session
        do_start();
        send(mk(3, 0, 0, 9, 9, 0, 25'd77, 1'b0));
        chk("rstw_in_write", 64'(bus.imem_we), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rstw");
        snap = wr_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstw_no_write", 64'(wr_cnt), 64'(snap));
        chk("rstw_idle", 64'({busy, bus.in_ready}), 64'd0);

        // Random sessions against the reference model
        for (int s = 0; s < 60; s++) begin
            int len = $urandom_range(1, 4);
            do_start();
            for (int i = 0; i < len; i++) begin
                d.mnem  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
                d.funct = 3'($urandom);
                d.vec   = 1'($urandom);
                d.rd    = 5'($urandom);
                d.rn    = 5'($urandom);
                d.rm    = 5'($urandom);
                d.imm   = ($urandom_range(0, 3) == 0) ? 25'($urandom)
                                                      : 25'(int'($urandom_range(0, 32767)) - 16384);
                d.last  = (i == len - 1);
                model(d, el, ew);
                xfer(d, el, ew, i, $sformatf("rnd%0d_%0d", s, i));
                if (!el) break;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
